// File: rtl/dmem_pkg.sv
// Shared types and widths for the handshaked data-memory responder.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
    localparam int DMEM_WORD_W = 32;
    localparam int DMEM_LAT_W  = 4;
endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the datapath (master) and the data memory (slave).
interface dmem_responder_if;
    import dmem_pkg::*;
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [DMEM_WORD_W-1:0] req_addr;
    logic [DMEM_WORD_W-1:0] req_wdata;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DMEM_WORD_W-1:0] rsp_rdata;
    logic                   rsp_err;
    logic                   busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, DEPTH x 32, write enable plus registered read; no reset on contents.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic                   re,
    input  logic [AW-1:0]          idx,
    input  logic [DMEM_WORD_W-1:0] wdata,
    output logic [DMEM_WORD_W-1:0] rdata
);
    logic [DMEM_WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
        if (re) rdata <= mem[idx];
    end
endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data RAM behind a valid/ready request/response port with LATENCY wait states.
// Optional misalignment check enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    dmem_state_t            state;
    logic [DMEM_LAT_W-1:0]  cnt;
    logic                   write_q;
    logic [DMEM_WORD_W-1:0] addr_q;
    logic [DMEM_WORD_W-1:0] wdata_q;
    logic                   rsp_valid_q;
    logic                   rsp_err_q;
    logic                   rsp_load_q;

    logic                   acc_write;
    logic [DMEM_WORD_W-1:0] acc_addr;
    logic [DMEM_WORD_W-1:0] acc_wdata;
    logic                   aligned;
    logic                   access;
    logic                   ram_we;
    logic                   ram_re;
    logic [DMEM_WORD_W-1:0] ram_rdata;
    logic                   unused_addr_bits;

    // With zero wait states the access happens on the accept edge, straight from the bus.
    assign acc_write = (LATENCY == 0) ? bus.req_write : write_q;
    assign acc_addr  = (LATENCY == 0) ? bus.req_addr  : addr_q;
    assign acc_wdata = (LATENCY == 0) ? bus.req_wdata : wdata_q;

`ifdef DMEM_ALIGN_CHECK_EN
    assign aligned = (acc_addr[1:0] == 2'b00);
`else
    assign aligned = 1'b1;
`endif

    assign access = !reset && ((LATENCY == 0) ? (state == IDLE && bus.req_valid)
                                              : (state == WAIT && cnt == DMEM_LAT_W'(1)));
    assign ram_we = access && acc_write && aligned;
    assign ram_re = access && !acc_write && aligned;
    assign unused_addr_bits = ^{acc_addr[DMEM_WORD_W-1:AW+2], acc_addr[1:0]};

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .idx   (acc_addr[AW+1:2]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (state == IDLE && bus.req_valid) begin
            write_q <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    if (LATENCY == 0) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= !aligned;
                        rsp_load_q  <= !acc_write && aligned;
                    end else begin
                        state <= WAIT;
                        cnt   <= DMEM_LAT_W'(LATENCY);
                    end
                end
                WAIT: begin
                    cnt <= cnt - DMEM_LAT_W'(1);
                    if (cnt == DMEM_LAT_W'(1)) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= !aligned;
                        rsp_load_q  <= !acc_write && aligned;
                    end
                end
                RESP: if (bus.rsp_ready) begin
                    state       <= IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_load_q  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_load_q ? ram_rdata : '0;
`ifdef DMEM_ALIGN_CHECK_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 and LATENCY=0 instances against a transaction-level memory model.
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_k [2];
    logic        rv [2];
    logic        rw [2];
    logic [31:0] ra [2];
    logic [31:0] rwd [2];
    logic        rr [2];
    logic        o_ready [2];
    logic        o_valid [2];
    logic        o_err [2];
    logic        o_busy [2];
    logic [31:0] o_rdata [2];

    dmem_responder_if bus2 ();
    dmem_responder_if bus0 ();

    assign bus2.req_valid = rv[0];
    assign bus2.req_write = rw[0];
    assign bus2.req_addr  = ra[0];
    assign bus2.req_wdata = rwd[0];
    assign bus2.rsp_ready = rr[0];
    assign o_ready[0] = bus2.req_ready;
    assign o_valid[0] = bus2.rsp_valid;
    assign o_err[0]   = bus2.rsp_err;
    assign o_busy[0]  = bus2.busy;
    assign o_rdata[0] = bus2.rsp_rdata;

    assign bus0.req_valid = rv[1];
    assign bus0.req_write = rw[1];
    assign bus0.req_addr  = ra[1];
    assign bus0.req_wdata = rwd[1];
    assign bus0.rsp_ready = rr[1];
    assign o_ready[1] = bus0.req_ready;
    assign o_valid[1] = bus0.rsp_valid;
    assign o_err[1]   = bus0.rsp_err;
    assign o_busy[1]  = bus0.busy;
    assign o_rdata[1] = bus0.rsp_rdata;

    dmem_responder #(.DEPTH(1024), .LATENCY(2)) dut2 (.clk(clk), .reset(reset_k[0]), .bus(bus2.slave));
    dmem_responder #(.DEPTH(1024), .LATENCY(0)) dut0 (.clk(clk), .reset(reset_k[1]), .bus(bus0.slave));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int lats [2] = '{2, 0};

    task automatic check(input string nm, input int k, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s dut=%0d got=%h want=%h t=%0t", nm, k, got, want, $time);
        end
    endtask

    // Transaction-level model: memory image, one outstanding request, edges left until the access.
    logic [31:0] mmem   [2][1024];
    bit          mknown [2][1024];
    bit          m_busy [2];
    bit          m_rsp  [2];
    bit          m_err  [2];
    bit          m_rdk  [2];
    logic [31:0] m_rd   [2];
    int          m_left [2];
    bit          m_w    [2];
    logic [31:0] m_a    [2];
    logic [31:0] m_d    [2];

    task automatic model_access(input int k);
        int idx;
        bit mis;
        idx = int'(m_a[k] / 4) % 1024;
`ifdef DMEM_ALIGN_CHECK_EN
        mis = (m_a[k] % 4) != 0;
`else
        mis = 1'b0;
`endif
        m_rsp[k] = 1'b1;
        m_err[k] = mis;
        m_rdk[k] = 1'b1;
        m_rd[k]  = 32'h0;
        if (!mis) begin
            if (m_w[k]) begin
                mmem[k][idx]   = m_d[k];
                mknown[k][idx] = 1'b1;
            end else begin
                m_rd[k]  = mmem[k][idx];
                m_rdk[k] = mknown[k][idx];
            end
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset_k[k]) begin
                m_busy[k] = 1'b0;
                m_rsp[k]  = 1'b0;
                m_err[k]  = 1'b0;
            end else if (m_rsp[k]) begin
                if (rr[k]) begin
                    m_busy[k] = 1'b0;
                    m_rsp[k]  = 1'b0;
                    m_err[k]  = 1'b0;
                end
            end else if (m_busy[k]) begin
                m_left[k]--;
                if (m_left[k] == 0) model_access(k);
            end else if (rv[k]) begin
                m_busy[k] = 1'b1;
                m_w[k]    = rw[k];
                m_a[k]    = ra[k];
                m_d[k]    = rwd[k];
                m_left[k] = lats[k];
                if (m_left[k] == 0) model_access(k);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check("m_ready", k, o_ready[k], !m_busy[k]);
                check("m_valid", k, o_valid[k], m_rsp[k]);
                check("m_busy",  k, o_busy[k],  m_busy[k]);
                check("m_err",   k, o_err[k],   m_err[k]);
                if (!m_rsp[k])     check("m_rdata_idle", k, o_rdata[k], 32'h0);
                else if (m_rdk[k]) check("m_rdata",      k, o_rdata[k], m_rd[k]);
            end
        end
    end

    // Called at a negedge; returns at a negedge with the response consumed.
    task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input int bp, output logic [31:0] rd, output logic er);
        int n;
        rr[k] = (bp == 0);
        rv[k] = 1'b1; rw[k] = w; ra[k] = a; rwd[k] = d;
        n = 0;
        while (!o_ready[k] && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("accept_timeout", k, 32'(n), 32'(0));
        @(negedge clk);
        rv[k] = 1'b0; rw[k] = 1'b0; ra[k] = $urandom; rwd[k] = $urandom;
        n = 0;
        while (!o_valid[k] && n < 50) begin @(negedge clk); n++; end
        check("latency", k, 32'(n), 32'(lats[k]));
        rd = o_rdata[k];
        er = o_err[k];
        repeat (bp) @(negedge clk);
        rr[k] = 1'b1;
        @(negedge clk);
        check("rsp_done", k, o_valid[k], 1'b0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          n;
        logic [31:0] a;
        for (int k = 0; k < 2; k++) begin
            reset_k[k] = 1'b1; rv[k] = 1'b0; rw[k] = 1'b0;
            ra[k] = 32'h0; rwd[k] = 32'h0; rr[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_ready", k, o_ready[k], 1'b1);
            check("rst_valid", k, o_valid[k], 1'b0);
            check("rst_busy",  k, o_busy[k],  1'b0);
            check("rst_rdata", k, o_rdata[k], 32'h0);
            check("rst_err",   k, o_err[k],   1'b0);
        end
        reset_k[0] = 1'b0; reset_k[1] = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, rd, er);
        check("st_rdata", 0, rd, 32'h0);
        txn(0, 1'b0, 32'h10, 32'h0, 0, rd, er);
        check("ld_rdata", 0, rd, 32'hDEADBEEF);

        // Backpressure with a stray request pulse while the response is held.
        rr[0] = 1'b0; rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 32'h10;
        @(negedge clk);
        rv[0] = 1'b0;
        n = 0;
        while (!o_valid[0] && n < 50) begin @(negedge clk); n++; end
        check("bp_latency", 0, 32'(n), 32'd2);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 0, o_valid[0], 1'b1);
            check("bp_rdata", 0, o_rdata[0], 32'hDEADBEEF);
            check("bp_ready", 0, o_ready[0], 1'b0);
            if (i == 1) begin rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h10; rwd[0] = 32'h1; end
            else rv[0] = 1'b0;
            @(negedge clk);
        end
        rv[0] = 1'b0; rw[0] = 1'b0;
        rr[0] = 1'b1;
        @(negedge clk);
        check("bp_release", 0, o_valid[0], 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 0, rd, er);
        check("bp_keep", 0, rd, 32'hDEADBEEF);

        txn(0, 1'b1, 32'h1000, 32'hCAFEF00D, 0, rd, er);
        txn(0, 1'b0, 32'h0, 32'h0, 0, rd, er);
        check("wrap", 0, rd, 32'hCAFEF00D);

        // Reset while a store waits: the store must be discarded.
        txn(0, 1'b1, 32'h20, 32'h11112222, 0, rd, er);
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h20; rwd[0] = 32'h33334444;
        @(negedge clk);
        rv[0] = 1'b0; rw[0] = 1'b0;
        check("rstw_busy_pre", 0, o_busy[0], 1'b1);
        reset_k[0] = 1'b1;
        repeat (2) @(negedge clk);
        reset_k[0] = 1'b0;
        check("rstw_busy",  0, o_busy[0],  1'b0);
        check("rstw_ready", 0, o_ready[0], 1'b1);
        txn(0, 1'b0, 32'h20, 32'h0, 0, rd, er);
        check("rstw_keep", 0, rd, 32'h11112222);

`ifdef DMEM_ALIGN_CHECK_EN
        txn(0, 1'b1, 32'h13, 32'h5555AAAA, 0, rd, er);
        check("mis_err",   0, er, 1'b1);
        check("mis_rdata", 0, rd, 32'h0);
        txn(0, 1'b0, 32'h10, 32'h0, 0, rd, er);
        check("mis_keep", 0, rd, 32'hDEADBEEF);
        check("mis_ld_err", 0, er, 1'b0);
`else
        txn(0, 1'b1, 32'h13, 32'h5555AAAA, 0, rd, er);
        check("lowbits_err", 0, er, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 0, rd, er);
        check("lowbits_ignored", 0, rd, 32'h5555AAAA);
`endif

        // Zero wait states: back-to-back requests accepted every second edge.
        txn(1, 1'b1, 32'h40, 32'hA5A5A5A5, 0, rd, er);
        txn(1, 1'b0, 32'h40, 32'h0, 0, rd, er);
        check("l0_ld", 1, rd, 32'hA5A5A5A5);
        rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 32'h40;
        check("l0_p0_ready", 1, o_ready[1], 1'b1);
        @(negedge clk);
        check("l0_p1_ready", 1, o_ready[1], 1'b0);
        check("l0_p1_valid", 1, o_valid[1], 1'b1);
        check("l0_p1_rdata", 1, o_rdata[1], 32'hA5A5A5A5);
        @(negedge clk);
        check("l0_p2_ready", 1, o_ready[1], 1'b1);
        check("l0_p2_valid", 1, o_valid[1], 1'b0);
        @(negedge clk);
        check("l0_p3_ready", 1, o_ready[1], 1'b0);
        check("l0_p3_valid", 1, o_valid[1], 1'b1);
        rv[1] = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 120; i++) begin
                a = (32'($urandom_range(0, 7)) << 12) | (32'($urandom_range(0, 15)) << 2);
                if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
                txn(k, 1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 2)), rd, er);
                repeat ($urandom_range(0, 1)) @(negedge clk);
            end
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
